// File: rtl/mc_core_pkg.sv
// Shared types and instruction-field helpers for the multi-cycle 9-bit-ISA core.
package mc_core_pkg;

  localparam int unsigned IR_W   = 9;
  localparam int unsigned FLD_W  = 3;
  localparam int unsigned IMM_W  = 6;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RA_LSB = 3;
  localparam int unsigned RB_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_MOVI = 3'd6,
    OP_BZ   = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic op_t ir_op(input logic [IR_W-1:0] ir);
    return op_t'(ir[OP_LSB +: FLD_W]);
  endfunction

  function automatic logic [FLD_W-1:0] ir_ra(input logic [IR_W-1:0] ir);
    return ir[RA_LSB +: FLD_W];
  endfunction

  function automatic logic [FLD_W-1:0] ir_rb(input logic [IR_W-1:0] ir);
    return ir[RB_LSB +: FLD_W];
  endfunction

  function automatic logic [IMM_W-1:0] ir_imm(input logic [IR_W-1:0] ir);
    return ir[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the register-register ops; zero feeds the Z flag.
module mc_alu
  import mc_core_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] rslt,
  output logic         zero
);

  always_comb begin
    rslt = a;
    case (op)
      OP_ADD:  rslt = a + b;
      OP_SUB:  rslt = a - b;
      OP_AND:  rslt = a & b;
      OP_XOR:  rslt = a ^ b;
      default: rslt = a;
    endcase
    zero = (rslt == '0);
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 9-bit-ISA core: PC, IR, Z flag, register file and sequencing FSM.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int unsigned D       = 12,
  parameter int unsigned W       = 8,
  parameter int unsigned NREG    = 8,
  parameter int unsigned DONE_PC = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            done,
  output logic [D-1:0]    imem_addr,
  input  logic [IR_W-1:0] imem_data,
  output logic [W-1:0]    dmem_addr,
  output logic [W-1:0]    dmem_wdata,
  output logic            dmem_we,
  input  logic [W-1:0]    dmem_rdata
);

  state_t state, state_d;

  logic [D-1:0]     pc, pc_nxt, pc_inc, pc_br, br_off;
  logic [IR_W-1:0]  ir;
  logic             z;
  logic [W-1:0]     regs [NREG];

  op_t                     op;
  logic [FLD_W-1:0]        ra, rb;
  logic [IMM_W-1:0]        imm;
  logic signed [IMM_W-1:0] imm_s;

  logic [W-1:0]     alu_rslt;
  logic             alu_zero;

  logic             pc_we, z_we, rf_we;
  logic [FLD_W-1:0] rf_wa;
  logic [W-1:0]     rf_wd;

  assign op    = ir_op(ir);
  assign ra    = ir_ra(ir);
  assign rb    = ir_rb(ir);
  assign imm   = ir_imm(ir);
  assign imm_s = imm;

  // Signed size cast sign-extends (or truncates) the offset; PC math wraps mod 2**D.
  assign br_off = D'(imm_s);
  assign pc_inc = pc + D'(1);
  assign pc_br  = pc + br_off;
  assign pc_nxt = (op == OP_BZ && z) ? pc_br : pc_inc;

  assign imem_addr = pc;

  mc_alu #(.W(W)) u_alu (
    .op   (op),
    .a    (regs[ra]),
    .b    (regs[rb]),
    .rslt (alu_rslt),
    .zero (alu_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state plus regfile / flag / PC write controls.
  always_comb begin
    state_d = state;
    pc_we   = 1'b0;
    z_we    = 1'b0;
    rf_we   = 1'b0;
    rf_wa   = ra;
    rf_wd   = alu_rslt;
    case (state)
      ST_IDLE:  if (req) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            rf_we = 1'b1;
            z_we  = 1'b1;
          end
          OP_MOVI: begin
            rf_we = 1'b1;
            rf_wa = '0;
            rf_wd = W'(imm);
          end
          default: ;
        endcase
        if (op == OP_LD) begin
          state_d = ST_MEM;
        end else begin
          pc_we   = 1'b1;
          state_d = (pc_nxt == D'(DONE_PC)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_MEM: begin
        rf_we   = 1'b1;
        rf_wd   = dmem_rdata;
        pc_we   = 1'b1;
        state_d = (pc_nxt == D'(DONE_PC)) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  if (!req) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Data memory controls are registered during FETCH so they are valid throughout EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ir         <= '0;
      z          <= 1'b0;
      done       <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        pc <= '0;
        z  <= 1'b0;
      end else begin
        if (pc_we) pc <= pc_nxt;
        if (z_we)  z  <= alu_zero;
      end
      if (state == ST_FETCH) begin
        ir         <= imem_data;
        dmem_addr  <= regs[ir_rb(imem_data)];
        dmem_wdata <= regs[ir_ra(imem_data)];
      end
      if (rf_we) regs[rf_wa] <= rf_wd;
      dmem_we <= (state == ST_FETCH) && (ir_op(imem_data) == OP_ST);
      done    <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Testbench for mc_core: directed scenarios plus random programs checked against an ISA-level model.
module tb_mc_core;

  logic       clk;
  logic       reset;
  logic       req_a, req_b;
  logic       done_a, done_b, we_a, we_b;
  logic [11:0] imem_addr_a;
  logic [3:0]  imem_addr_b;
  logic [8:0]  imem_data_a, imem_data_b;
  logic [7:0]  daddr_a, wdata_a, rdata_a;
  logic [7:0]  daddr_b, wdata_b, rdata_b;

  logic [8:0] imem [128];
  logic [7:0] dmem [256];
  logic       tb_we;
  logic [7:0] tb_wa, tb_wd;

  int n_tests, n_fail;

  int         obs_pc [$];
  logic [7:0] obs_sa [$];
  logic [7:0] obs_sd [$];
  logic [7:0] obs_da [$];

  logic [7:0] m_regs [8];
  logic [7:0] m_mem  [256];
  logic [7:0] exp_sa [$];
  logic [7:0] exp_sd [$];

  mc_core #(.D(12), .W(8), .NREG(8), .DONE_PC(4)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .done(done_a),
    .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .dmem_addr(daddr_a), .dmem_wdata(wdata_a), .dmem_we(we_a), .dmem_rdata(rdata_a)
  );

  mc_core #(.D(4), .W(8), .NREG(8), .DONE_PC(15)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .done(done_b),
    .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .dmem_addr(daddr_b), .dmem_wdata(wdata_b), .dmem_we(we_b), .dmem_rdata(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data_a = imem[imem_addr_a[6:0]];
  assign imem_data_b = imem[{3'b000, imem_addr_b}];

  // External data memory: one-cycle read latency, stores on the clock edge.
  always @(posedge clk) begin
    rdata_a <= dmem[daddr_a];
    rdata_b <= dmem[daddr_b];
    if (we_a)  dmem[daddr_a] <= wdata_a;
    if (we_b)  dmem[daddr_b] <= wdata_b;
    if (tb_we) dmem[tb_wa]   <= tb_wd;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    m_mem[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load4(input logic [8:0] p0, input logic [8:0] p1,
                       input logic [8:0] p2, input logic [8:0] p3);
    imem[0] = p0; imem[1] = p1; imem[2] = p2; imem[3] = p3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
  endtask

  // Raise req and record PC changes, stores and dmem_addr until done or budget expiry.
  task automatic run_dut(input bit sel, input int budget, output int cyc);
    int   last_pc, cur_pc;
    logic dn;
    obs_pc.delete(); obs_sa.delete(); obs_sd.delete(); obs_da.delete();
    @(negedge clk);
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    cyc = 0; last_pc = -1; dn = 1'b0;
    while (!dn && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      cur_pc = sel ? int'(imem_addr_b) : int'(imem_addr_a);
      if (cur_pc != last_pc) begin
        obs_pc.push_back(cur_pc);
        last_pc = cur_pc;
      end
      obs_da.push_back(sel ? daddr_b : daddr_a);
      if (sel ? we_b : we_a) begin
        obs_sa.push_back(sel ? daddr_b : daddr_a);
        obs_sd.push_back(sel ? wdata_b : wdata_a);
      end
      dn = sel ? done_b : done_a;
    end
    if (!dn) cyc = -1;
  endtask

  task automatic release_req(input bit sel);
    @(negedge clk);
    if (sel) req_b = 1'b0; else req_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (done_a !== 1'b0 || done_b !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b/%b expected 0/0", done_a, done_b); end
    n_tests++; if (we_a !== 1'b0 || we_b !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b/%b expected 0/0", we_a, we_b); end
    n_tests++; if (imem_addr_a !== 12'd0 || imem_addr_b !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d/%0d expected 0/0", imem_addr_a, imem_addr_b); end
    n_tests++; if (daddr_a !== 8'd0 || wdata_a !== 8'd0) begin n_fail++; $display("FAIL reset_dmem: got %0d/%0d expected 0/0", daddr_a, wdata_a); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_store_seq();
    int cyc;
    load4(9'h185, 9'h008, 9'h008, 9'h148);
    run_dut(1'b0, 40, cyc);
    n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL t1_cycles: got %0d expected 9", cyc); end
    n_tests++; if (obs_sa.size() !== 1) begin n_fail++; $display("FAIL t1_store_count: got %0d expected 1", obs_sa.size()); end
    if (obs_sa.size() > 0) begin
      n_tests++; if (obs_sa[0] !== 8'd5 || obs_sd[0] !== 8'd10) begin n_fail++; $display("FAIL t1_store: got %0d/%0d expected 5/10", obs_sa[0], obs_sd[0]); end
    end
    n_tests++; if (obs_pc.size() !== 5) begin n_fail++; $display("FAIL t1_pc_count: got %0d expected 5", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size() && i < 5; i++) begin
      n_tests++; if (obs_pc[i] !== i) begin n_fail++; $display("FAIL t1_pc[%0d]: got %0d expected %0d", i, obs_pc[i], i); end
    end
    release_req(1'b0);
  endtask

  task automatic test_hold_restart();
    int cyc;
    load4(9'h185, 9'h008, 9'h008, 9'h148);
    run_dut(1'b0, 40, cyc);
    n_tests++; if (obs_sa.size() !== 1 || obs_sd.size() < 1 || obs_sd[0] !== 8'd20) begin n_fail++; $display("FAIL t6_first_store: got count %0d expected one store of 20", obs_sa.size()); end
    repeat (5) @(negedge clk);
    n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL t6_done_held: got %b expected 1", done_a); end
    req_a = 1'b0;
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL t6_done_drop: got %b expected 0", done_a); end
    load4(9'h148, 9'h148, 9'h148, 9'h148);
    run_dut(1'b0, 40, cyc);
    n_tests++; if (obs_pc.size() < 1 || obs_pc[0] !== 0) begin n_fail++; $display("FAIL t6_restart_pc: got %0d expected 0", obs_pc.size() > 0 ? obs_pc[0] : -1); end
    n_tests++; if (obs_sa.size() !== 4) begin n_fail++; $display("FAIL t6_store_count: got %0d expected 4", obs_sa.size()); end
    for (int i = 0; i < obs_sa.size(); i++) begin
      n_tests++; if (obs_sa[i] !== 8'd5 || obs_sd[i] !== 8'd20) begin n_fail++; $display("FAIL t6_store[%0d]: got %0d/%0d expected 5/20", i, obs_sa[i], obs_sd[i]); end
    end
    n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL t6_cycles: got %0d expected 9", cyc); end
    release_req(1'b0);
  endtask

  task automatic test_branch();
    int cyc;
    int exp_pc [4] = '{0, 1, 3, 4};
    load4(9'h040, 9'h1C2, 9'h185, 9'h000);
    run_dut(1'b0, 40, cyc);
    n_tests++; if (cyc !== 7) begin n_fail++; $display("FAIL t2_cycles: got %0d expected 7", cyc); end
    n_tests++; if (obs_pc.size() !== 4) begin n_fail++; $display("FAIL t2_pc_count: got %0d expected 4", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size() && i < 4; i++) begin
      n_tests++; if (obs_pc[i] !== exp_pc[i]) begin n_fail++; $display("FAIL t2_pc[%0d]: got %0d expected %0d", i, obs_pc[i], exp_pc[i]); end
    end
    release_req(1'b0);
    load4(9'h140, 9'h140, 9'h140, 9'h140);
    run_dut(1'b0, 40, cyc);
    n_tests++; if (obs_sa.size() !== 4) begin n_fail++; $display("FAIL t2_r0_store_count: got %0d expected 4", obs_sa.size()); end
    if (obs_sa.size() > 0) begin
      n_tests++; if (obs_sa[0] !== 8'd0 || obs_sd[0] !== 8'd0) begin n_fail++; $display("FAIL t2_r0_zero: got %0d/%0d expected 0/0", obs_sa[0], obs_sd[0]); end
    end
    release_req(1'b0);
  endtask

  task automatic test_load();
    int cyc;
    poke(8'd5, 8'hA5);
    load4(9'h185, 9'h108, 9'h148, 9'h148);
    run_dut(1'b0, 40, cyc);
    n_tests++; if (cyc !== 10) begin n_fail++; $display("FAIL t3_cycles: got %0d expected 10", cyc); end
    n_tests++; if (obs_da.size() < 4 || obs_da[3] !== 8'd5) begin n_fail++; $display("FAIL t3_ld_addr: got %0d expected 5", obs_da.size() >= 4 ? int'(obs_da[3]) : -1); end
    n_tests++; if (obs_sa.size() !== 2) begin n_fail++; $display("FAIL t3_store_count: got %0d expected 2", obs_sa.size()); end
    for (int i = 0; i < obs_sa.size(); i++) begin
      n_tests++; if (obs_sa[i] !== 8'd5 || obs_sd[i] !== 8'hA5) begin n_fail++; $display("FAIL t3_r1[%0d]: got %0d/%h expected 5/a5", i, obs_sa[i], obs_sd[i]); end
    end
    release_req(1'b0);
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    load4(9'h185, 9'h108, 9'h148, 9'h148);
    @(negedge clk);
    req_a = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_tests++; if (imem_addr_a !== 12'd1 || done_a !== 1'b0) begin n_fail++; $display("FAIL t5_in_mem: got pc %0d done %b expected pc 1 done 0", imem_addr_a, done_a); end
    reset = 1'b0;
    #1;
    n_tests++; if (we_a !== 1'b0 || done_a !== 1'b0 || imem_addr_a !== 12'd0) begin n_fail++; $display("FAIL t5_async_reset: got we %b done %b pc %0d expected 0 0 0", we_a, done_a, imem_addr_a); end
    req_a = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (imem_addr_a !== 12'd0 || done_a !== 1'b0) begin n_fail++; $display("FAIL t5_idle_wait: got pc %0d done %b expected 0 0", imem_addr_a, done_a); end
    load4(9'h140, 9'h140, 9'h140, 9'h140);
    run_dut(1'b0, 40, cyc);
    n_tests++; if (cyc !== 9 || obs_sa.size() !== 4) begin n_fail++; $display("FAIL t5_rerun: got cyc %0d stores %0d expected 9 4", cyc, obs_sa.size()); end
    if (obs_sa.size() > 0) begin
      n_tests++; if (obs_sa[0] !== 8'd0 || obs_sd[0] !== 8'd0) begin n_fail++; $display("FAIL t5_regs_cleared: got %0d/%0d expected 0/0", obs_sa[0], obs_sd[0]); end
    end
    release_req(1'b0);
  endtask

  task automatic test_pc_wrap();
    int cyc;
    int exp_pc [5] = '{0, 1, 2, 0, 15};
    load4(9'h1FF, 9'h040, 9'h1FE, 9'h000);
    run_dut(1'b1, 40, cyc);
    n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL t4_cycles: got %0d expected 9", cyc); end
    n_tests++; if (obs_pc.size() !== 5) begin n_fail++; $display("FAIL t4_pc_count: got %0d expected 5", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size() && i < 5; i++) begin
      n_tests++; if (obs_pc[i] !== exp_pc[i]) begin n_fail++; $display("FAIL t4_pc[%0d]: got %0d expected %0d", i, obs_pc[i], exp_pc[i]); end
    end
    n_tests++; if (done_b !== 1'b1 || imem_addr_b !== 4'd15) begin n_fail++; $display("FAIL t4_done: got done %b pc %0d expected 1 15", done_b, imem_addr_b); end
    release_req(1'b1);
  endtask

  // ISA interpreter: runs imem from PC 0 until PC 15, producing the expected stores and cycle count.
  task automatic model_b(output bit ok, output int exp_cyc);
    logic [7:0] r   [8];
    logic [7:0] mem [256];
    logic [8:0] ir;
    logic [2:0] a, b;
    logic [7:0] res;
    int         pc;
    bit         z;
    r = m_regs; mem = m_mem;
    exp_sa.delete(); exp_sd.delete();
    pc = 0; z = 1'b0; ok = 1'b0; exp_cyc = 0;
    for (int s = 0; s < 60 && !ok; s++) begin
      ir = imem[pc];
      a  = ir[5:3];
      b  = ir[2:0];
      exp_cyc += 2;
      case (ir[8:6])
        3'd0: begin res = r[a] + r[b]; r[a] = res; z = (res == 8'd0); pc = pc + 1; end
        3'd1: begin res = r[a] - r[b]; r[a] = res; z = (res == 8'd0); pc = pc + 1; end
        3'd2: begin res = r[a] & r[b]; r[a] = res; z = (res == 8'd0); pc = pc + 1; end
        3'd3: begin res = r[a] ^ r[b]; r[a] = res; z = (res == 8'd0); pc = pc + 1; end
        3'd4: begin r[a] = mem[r[b]]; exp_cyc += 1; pc = pc + 1; end
        3'd5: begin mem[r[b]] = r[a]; exp_sa.push_back(r[b]); exp_sd.push_back(r[a]); pc = pc + 1; end
        3'd6: begin r[0] = {2'b00, ir[5:0]}; pc = pc + 1; end
        default: pc = z ? pc + int'($signed(ir[5:0])) : pc + 1;
      endcase
      pc = pc & 15;
      if (pc == 15) ok = 1'b1;
    end
    if (ok) begin
      m_regs = r;
      m_mem  = mem;
    end
  endtask

  task automatic test_random();
    int cyc, exp_cyc, n_st;
    bit ok;
    do_reset();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    for (int run = 0; run < 25; run++) begin
      ok = 1'b0;
      for (int tries = 0; tries < 50 && !ok; tries++) begin
        for (int i = 0; i < 16; i++) imem[i] = 9'($urandom);
        model_b(ok, exp_cyc);
      end
      if (ok) begin
        run_dut(1'b1, 300, cyc);
        n_tests++; if (cyc !== exp_cyc + 1) begin n_fail++; $display("FAIL rand%0d_cycles: got %0d expected %0d", run, cyc, exp_cyc + 1); end
        n_tests++; if (obs_sa.size() !== exp_sa.size()) begin n_fail++; $display("FAIL rand%0d_store_count: got %0d expected %0d", run, obs_sa.size(), exp_sa.size()); end
        n_st = (obs_sa.size() < exp_sa.size()) ? obs_sa.size() : exp_sa.size();
        for (int i = 0; i < n_st; i++) begin
          n_tests++; if (obs_sa[i] !== exp_sa[i] || obs_sd[i] !== exp_sd[i]) begin n_fail++; $display("FAIL rand%0d_store[%0d]: got %h/%h expected %h/%h", run, i, obs_sa[i], obs_sd[i], exp_sa[i], exp_sd[i]); end
        end
        release_req(1'b1);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    tb_we = 1'b0; tb_wa = 8'd0; tb_wd = 8'd0;
    for (int i = 0; i < 128; i++) imem[i] = 9'h000;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    test_reset();
    test_store_seq();
    test_hold_restart();
    test_branch();
    test_load();
    test_reset_mid_load();
    do_reset();
    test_pc_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
